ram_2p_bfm: RTL and testbench
=============================

// Module: ram_2p_bfm
// PURPOSE
//  Parametrised simple-dual-port block RAM: one write port with a byte mask, one read port.
//  Adds a configurable read latency, read-during-write bypass, out-of-range detection and
//  optional zero-clear after reset. Backs the core's instruction and data memories and the
//  testbench memory models; maps to block RAM.
// PARAMETERS
//  DATA_WIDTH    32    word width in bits; must be a multiple of BYTE_SIZE
//  BYTE_SIZE     8     bits per write-enable lane
//  ADDR_WIDTH    10    address width
//  RAM_DEPTH     1024  number of words; 1 <= RAM_DEPTH <= 2**ADDR_WIDTH
//  RD_LATENCY    1     read latency in cycles; legal values 1 or 2
//  BYPASS        1     1: a same-cycle same-address read returns the new data; 0: it returns the old data
//  CLEAR_ON_RST  1     1: zero every word after reset; 0: ready immediately after reset
//  NUM_BYTES     DATA_WIDTH/BYTE_SIZE (derived; do not override)
// PORTS
//  clk        in   1           clock; all logic on the rising edge
//  rst        in   1           synchronous reset, active-high
//  init_done  out  1           1 = ports accepted; 0 during reset and during clear
//  wr_en      in   1           write request
//  wr_be      in   NUM_BYTES   byte-lane write enables
//  wr_addr    in   ADDR_WIDTH  write word address
//  wr_data    in   DATA_WIDTH  write data
//  rd_en      in   1           read request
//  rd_addr    in   ADDR_WIDTH  read word address
//  rd_data    out  DATA_WIDTH  read data; holds its last value between reads
//  rd_valid   out  1           one-cycle pulse per accepted read, aligned with rd_data
//  rd_err     out  1           read address >= RAM_DEPTH; aligned with rd_valid
// BEHAVIOUR
//  Reset values: rd_data=0, rd_valid=0, rd_err=0, init_done=0. Memory contents are not reset.
//  FSM states: ST_CLEAR, ST_READY.
//   - rst: go to ST_CLEAR if CLEAR_ON_RST=1, else ST_READY; clr_ptr=0.
//   - ST_CLEAR: write 0 to mem[clr_ptr] on every edge and increment clr_ptr.
//     After the write of RAM_DEPTH-1, go to ST_READY.
//     init_done rises exactly RAM_DEPTH cycles after rst deasserts.
//   - ST_READY: init_done=1. The FSM stays here until the next rst.
//  Reset asserted mid-clear restarts the clear from address 0.
//  While init_done=0:
//   - wr_en and rd_en are ignored; no rd_valid is produced.
//   - The read pipeline is flushed (valid bits cleared) on rst.
//  Write: accepted on an edge when wr_en && init_done.
//   - Byte lane i updates only if wr_be[i]=1.
//   - wr_be=0 is a no-op.
//   - wr_addr >= RAM_DEPTH: the write is dropped; it never aliases to another word.
//  Read: accepted on edge N when rd_en && init_done.
//   - RD_LATENCY=1: rd_data/rd_valid update on edge N+1.
//   - RD_LATENCY=2: they update on edge N+2.
//   - Fully pipelined: one read per cycle, results returned in order.
//   - rd_addr >= RAM_DEPTH: rd_data=0 and rd_err=1 with rd_valid.
//  Read and write to the same address on the same edge:
//   - BYPASS=1: result = wr_data on lanes with wr_be set, old word on the other lanes.
//   - BYPASS=0: result = old word.
//   - In both cases the memory takes the write.
//  Reads and writes to different addresses never interact.
//  Elaboration: illegal RD_LATENCY or RAM_DEPTH > 2**ADDR_WIDTH triggers $error.
// STRUCTURE
//  ram_pkg (shared header):
//   - state encodings ST_CLEAR/ST_READY
//   - RD_LAT_MIN=1, RD_LAT_MAX=2
//   - NUM_BYTES derivation macro
//  Sub-module ram_2p_array:
//   - storage array with per-lane masked write and registered raw read
//   - contains no reset logic, so it infers block RAM
//  The top level holds:
//   - the clear FSM and the write mux (clear vs. user write)
//   - range checks
//   - bypass merge
//   - optional second output register and the valid/err pipeline
// TESTING
//  1. CLEAR_ON_RST=1, RAM_DEPTH=16: release rst
//     -> init_done=1 exactly 16 cycles later; reads of addresses 0..15 all return 0.
//  2. Write 0xDEADBEEF to addr 5 with be=4'hF, then 0x0000AA00 with be=4'b0010
//     -> read of addr 5 returns 0xDEADAAEF.
//  3. Addr 3 holds 0x11223344; same edge: write 0x000000FF with be=4'h1 and read addr 3
//     -> BYPASS=1 returns 0x112233FF; BYPASS=0 returns 0x11223344; a later read returns 0x112233FF.
//  4. RD_LATENCY=2: back-to-back reads of addrs 0,1,2 (accepted on edges N..N+2)
//     -> rd_valid is high on edges N+2..N+4 with data in order; no bubbles.
//  5. RAM_DEPTH=1000: write 0x5A5A5A5A to addr 1000, then read addrs 1000 and 0
//     -> first read gives rd_data=0, rd_err=1; addr 0 is unchanged and its read gives rd_err=0.
//  6. rst pulsed when clr_ptr=7; rd_en held high throughout
//     -> no rd_valid until init_done; init_done rises RAM_DEPTH cycles after the second release.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared state encodings, latency limits and lane-count helper for ram_2p_bfm
package ram_pkg;
  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
  function automatic int calc_num_bytes(input int data_width, input int byte_size);
    return data_width / byte_size;
  endfunction
endpackage

// File: rtl/ram_2p_array.sv
// ram_2p_array: reset-free storage with per-lane masked write and registered raw read
module ram_2p_array #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RAM_DEPTH  = 1024,
  parameter int NUM_BYTES  = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [NUM_BYTES-1:0]  be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  // masked lane writes and a read-first registered read, no reset so it maps to block RAM
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++)
      if (we && be[i]) mem[waddr][i*BYTE_SIZE +: BYTE_SIZE] <= wdata[i*BYTE_SIZE +: BYTE_SIZE];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ram_2p_bfm.sv
// ram_2p_bfm: simple-dual-port RAM with clear-after-reset, bypass, range checks and 1/2-cycle read latency
module ram_2p_bfm import ram_pkg::*; #(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_SIZE    = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int RAM_DEPTH    = 1024,
  parameter int RD_LATENCY   = 1,
  parameter int BYPASS       = 1,
  parameter int CLEAR_ON_RST = 1,
  parameter int NUM_BYTES    = calc_num_bytes(DATA_WIDTH, BYTE_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  wr_en,
  input  logic [NUM_BYTES-1:0]  wr_be,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_err
);
  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX || RAM_DEPTH < 1 ||
      RAM_DEPTH > 2**ADDR_WIDTH || DATA_WIDTH % BYTE_SIZE != 0) begin : g_bad_params
    $error("ram_2p_bfm: illegal parameter combination");
  end

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic                    clearing, wr_in, rd_in, wr_ok, rd_ok, byp;
  logic                    arr_we;
  logic [NUM_BYTES-1:0]    arr_be;
  logic [ADDR_WIDTH-1:0]   arr_waddr;
  logic [DATA_WIDTH-1:0]   arr_wdata, raw, merged;
  logic                    va, ea, vb, eb, vc, ec;
  logic [NUM_BYTES-1:0]    bea;
  logic [DATA_WIDTH-1:0]   wda, db, dc;

  assign clearing  = state == ST_CLEAR && !rst;
  assign wr_in     = {1'b0, wr_addr} < (ADDR_WIDTH+1)'(RAM_DEPTH);
  assign rd_in     = {1'b0, rd_addr} < (ADDR_WIDTH+1)'(RAM_DEPTH);
  assign wr_ok     = wr_en && init_done && wr_in;
  assign rd_ok     = rd_en && init_done;
  assign byp       = BYPASS != 0 && wr_ok && wr_addr == rd_addr;
  assign arr_we    = clearing || wr_ok;
  assign arr_be    = clearing ? '1 : wr_be;
  assign arr_waddr = clearing ? clr_ptr : wr_addr;
  assign arr_wdata = clearing ? '0 : wr_data;

  ram_2p_array #(
    .DATA_WIDTH(DATA_WIDTH), .BYTE_SIZE(BYTE_SIZE), .ADDR_WIDTH(ADDR_WIDTH),
    .RAM_DEPTH(RAM_DEPTH), .NUM_BYTES(NUM_BYTES)
  ) u_array (
    .clk(clk), .we(arr_we), .be(arr_be), .waddr(arr_waddr), .wdata(arr_wdata),
    .re(rd_ok && rd_in), .raddr(rd_addr), .rdata(raw)
  );

  // clear FSM: sweep every word to zero after reset, then report ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR_ON_RST != 0 ? ST_CLEAR : ST_READY;
      clr_ptr   <= '0;
      init_done <= 1'b0;
    end else if (state == ST_CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
        state     <= ST_READY;
        init_done <= 1'b1;
      end
    end else begin
      init_done <= 1'b1;
    end
  end

  // overlay same-cycle write lanes onto the old word, and force zero for out-of-range reads
  always_comb begin
    merged = raw;
    for (int i = 0; i < NUM_BYTES; i++)
      if (bea[i]) merged[i*BYTE_SIZE +: BYTE_SIZE] = wda[i*BYTE_SIZE +: BYTE_SIZE];
    merged = ea ? '0 : merged;
  end

  // read pipeline: stage a tracks the array access, b and c are the output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      va <= 1'b0;
      vb <= 1'b0;
      eb <= 1'b0;
      db <= '0;
      vc <= 1'b0;
      ec <= 1'b0;
      dc <= '0;
    end else begin
      va <= rd_ok;
      if (rd_ok) begin
        ea  <= !rd_in;
        bea <= byp ? wr_be : '0;
        wda <= wr_data;
      end
      vb <= va;
      eb <= va && ea;
      if (va) db <= merged;
      vc <= vb;
      ec <= eb;
      if (vb) dc <= db;
    end
  end

  assign rd_valid = RD_LATENCY == RD_LAT_MAX ? vc : vb;
  assign rd_err   = RD_LATENCY == RD_LAT_MAX ? ec : eb;
  assign rd_data  = RD_LATENCY == RD_LAT_MAX ? dc : db;
endmodule

// File: tb/tb_ram_2p_bfm.sv
// tb_ram_2p_bfm: random traffic on two configurations checked against a timestamped memory model
module tb_ram_2p_bfm;
  localparam int AW    = 4;
  localparam int DEPTH = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0]    wr_be = '0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [31:0]   wr_data = '0;
  logic [1:0]    init_done, rd_valid, rd_err;
  logic [31:0]   rdata [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  int          cnt = 0;
  bit          m_init = 1'b0;
  longint      edge_n = 0;
  bit          pv [2][4];
  bit          pe [2][4];
  logic [31:0] pd [2][4];
  bit          ev [2];
  bit          ee [2];
  logic [31:0] ed [2];

  always #5 clk = ~clk;

  ram_2p_bfm #(.ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .RD_LATENCY(1), .BYPASS(1), .CLEAR_ON_RST(1)) u_dut0 (
    .clk(clk), .rst(rst), .init_done(init_done[0]), .wr_en(wr_en), .wr_be(wr_be),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdata[0]), .rd_valid(rd_valid[0]), .rd_err(rd_err[0])
  );

  ram_2p_bfm #(.ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .RD_LATENCY(2), .BYPASS(0), .CLEAR_ON_RST(1)) u_dut1 (
    .clk(clk), .rst(rst), .init_done(init_done[1]), .wr_en(wr_en), .wr_be(wr_be),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdata[1]), .rd_valid(rd_valid[1]), .rd_err(rd_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // effect of one rising edge, given the inputs the DUTs just sampled
  task automatic model_edge();
    bit          was_ready = m_init;
    bit          wr_acc = was_ready && wr_en && int'(wr_addr) < DEPTH;
    logic [31:0] old = mem[rd_addr];
    logic [31:0] rv;
    int          slot;
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      slot = int'(edge_n % 4);
      ev[k] = pv[k][slot];
      ee[k] = ev[k] && pe[k][slot];
      if (ev[k]) ed[k] = pd[k][slot];
      pv[k][slot] = 1'b0;
    end
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int s = 0; s < 4; s++) pv[k][s] = 1'b0;
        ev[k] = 1'b0;
        ee[k] = 1'b0;
        ed[k] = '0;
      end
    end else if (was_ready && rd_en) begin
      for (int k = 0; k < 2; k++) begin
        rv = old;
        if (k == 0 && wr_acc && wr_addr == rd_addr)
          for (int b = 0; b < 4; b++) if (wr_be[b]) rv[b*8 +: 8] = wr_data[b*8 +: 8];
        slot = int'((edge_n + k + 1) % 4);
        pv[k][slot] = 1'b1;
        pe[k][slot] = int'(rd_addr) >= DEPTH;
        pd[k][slot] = int'(rd_addr) >= DEPTH ? 32'h0 : rv;
      end
    end
    if (wr_acc)
      for (int b = 0; b < 4; b++) if (wr_be[b]) mem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
    if (rst) cnt = 0;
    else if (cnt < DEPTH) begin
      cnt++;
      if (cnt == DEPTH) for (int a = 0; a < 16; a++) mem[a] = '0;
    end
    m_init = cnt == DEPTH;
  endtask

  initial begin
    int rst_hold = 0;
    for (int k = 0; k < 2; k++) for (int s = 0; s < 4; s++) pv[k][s] = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_edge();
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("init_done%0d", k), 32'(init_done[k]), 32'(m_init));
        chk($sformatf("rd_valid%0d", k), 32'(rd_valid[k]), 32'(ev[k]));
        chk($sformatf("rd_err%0d", k), 32'(rd_err[k]), 32'(ee[k]));
        chk($sformatf("rd_data%0d", k), rdata[k], ed[k]);
      end
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 299) == 0) rst_hold = $urandom_range(1, 3);
      rst     = cyc < 2 || cyc == 9 || rst_hold > 0;
      wr_en   = $urandom_range(0, 9) < 7;
      rd_en   = cyc < 40 || $urandom_range(0, 9) < 7;
      wr_be   = 4'($urandom);
      wr_addr = AW'($urandom_range(0, 15));
      rd_addr = $urandom_range(0, 9) < 4 ? wr_addr : AW'($urandom_range(0, 15));
      wr_data = $urandom;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
